route_lkup_arbiter: RTL and testbench
=====================================

Name: route_lkup_arbiter

Overview:
Shares the routing table's single destination-lookup port (VALID/ACK/DSTMAC/PORT) among NREQ transmit-side requesters, one per egress packet source.
- Arbitrates round-robin and issues one lookup at a time.
- Returns the resulting NETH-bit port mask to the granted requester only.
- Sits between the per-port packet framers and the routing table.

Parameters:
NREQ, 4, number of lookup requesters (>=2)
NETH, 4, number of Ethernet ports (width of the port mask)
MACW, 48, bits in a MAC address
DEFAULT_PORT, {NETH{1'b1}}, mask returned when a lookup times out
LGTIMEOUT, 4, log2 of the lookup-timeout cycle count (used only with the optional feature)

Ports:
i_clk  in  1  system clock; the only clock
i_reset_n  in  1  synchronous, active-low reset
REQ_VALID  in  NREQ  per-requester lookup request; held until matching REQ_ACK or abandoned
REQ_DSTMAC  in  NREQ*MACW  per-requester destination MAC; requester n at [n*MACW +: MACW]
REQ_ACK  out  NREQ  one-hot, one-cycle pulse; REQ_PORT valid this cycle
REQ_PORT  out  NETH  lookup result; shared by all requesters
TBL_VALID  out  1  lookup request to the routing table
TBL_ACK  in  1  one-cycle routing-table acknowledge; TBL_PORT valid this cycle
TBL_DSTMAC  out  MACW  MAC under lookup
TBL_PORT  in  NETH  routing-table result
o_busy  out  1  high in any state other than IDLE
o_timeout  out  1  one-cycle pulse on lookup timeout (tied 0 without the macro)

Behaviour:
- Reset (i_reset_n==0 at a clock edge) sets: state=IDLE, REQ_ACK=0, REQ_PORT=0, TBL_VALID=0, TBL_DSTMAC=0, o_timeout=0, round-robin pointer=0 (requester 0 highest priority). All outputs are registered.
- Reset mid-lookup abandons the lookup. No REQ_ACK is issued. A TBL_ACK arriving after reset is ignored.
- State IDLE:
  - If |REQ_VALID, pick the first asserted requester at or after the pointer, cyclically.
  - Latch its index into gidx and its MAC into TBL_DSTMAC.
  - Set TBL_VALID=1 and go to WAIT.
- State WAIT:
  - TBL_VALID stays 1 and TBL_DSTMAC is held constant.
  - On TBL_ACK: TBL_VALID<=0, REQ_PORT<=TBL_PORT, go to RESP.
- State RESP (exactly one cycle):
  - REQ_ACK[gidx]=1 only if REQ_VALID[gidx] is still high; otherwise the result is discarded and REQ_ACK stays 0.
  - Pointer <= (gidx+1) mod NREQ, including when the result is discarded.
  - Go to IDLE.
- REQ_ACK is 0 in every other state.
- Latency:
  - Request seen in IDLE at cycle 0; TBL_VALID high from cycle 1.
  - With the routing table acking at cycle 2, REQ_ACK is high at cycle 3.
  - Minimum 3 cycles per lookup, so back-to-back throughput is one lookup per 3 cycles.
- REQ_DSTMAC changes after the grant have no effect; the latched copy is used.
- REQ_VALID of non-granted requesters may change freely. Arbitration happens only in IDLE.
- A TBL_ACK seen in IDLE or RESP is ignored.
- Requester count wrap-around: pointer NREQ-1 followed by a grant wraps to 0. The priority search wraps past NREQ-1.
- Only one lookup is ever outstanding.

Optional Feature:
Macro: ROUTE_LKUP_TIMEOUT_EN.
- Defined:
  - A LGTIMEOUT-bit counter clears on entry to WAIT and increments each WAIT cycle without TBL_ACK.
  - When the counter reaches all-ones without TBL_ACK: TBL_VALID<=0, REQ_PORT<=DEFAULT_PORT, o_timeout pulses for 1 cycle, go to RESP.
  - If TBL_ACK arrives in that same cycle, TBL_ACK wins.
- Not defined: no counter; WAIT waits indefinitely; o_timeout is tied 0.

Decomposition:
- Shared package/header route_pkg holds:
  - state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10);
  - default MACW=48 and the broadcast-MAC constant.
- One natural sub-module, route_rrpick: combinational round-robin picker with inputs req[NREQ] and ptr, outputs found and idx. It is reusable by other switch arbiters.

Test Plan:
- Reset then single request, NREQ=4: REQ_VALID=4'b0100, MAC 02:00:00:00:00:05; table model acks 1 cycle after TBL_VALID with TBL_PORT=4'b0010 -> TBL_VALID high at cycle 1; REQ_ACK=4'b0100 and REQ_PORT=4'b0010 at cycle 3; pointer=3.
- Fairness from reset: REQ_VALID=4'b1111 held, re-asserted after each ack -> grant order 0,1,2,3,0, with each REQ_ACK 3 cycles apart.
- Abandon: requester 1 drops REQ_VALID while in WAIT -> no REQ_ACK pulse; next IDLE grants requester 2 when 4'b0110 was pending.
- Stall: table model withholds TBL_ACK for 40 cycles -> TBL_VALID and TBL_DSTMAC stay constant, o_busy=1; with the macro and LGTIMEOUT=4, timeout after 15 WAIT cycles gives REQ_PORT=DEFAULT_PORT=4'b1111 and o_timeout pulses.
- Reset mid-WAIT: assert i_reset_n=0 for 1 cycle, then TBL_ACK arrives -> no REQ_ACK; all outputs 0; pointer back to 0.
- Spurious TBL_ACK in IDLE with TBL_PORT=4'b1000 -> REQ_PORT unchanged; no REQ_ACK.

Source files
------------

// File: rtl/route_pkg.sv
`default_nettype none
// ============================================================================
// Package     : route_pkg
// Description : Shared types and constants for the routing-table lookup path.
//               - state_t     : lookup arbiter FSM encoding
//               - MACW_DEF    : default MAC-address width
//               - BCAST_MAC   : broadcast destination MAC
// Revision    : 1.0 - initial release
// ============================================================================
package route_pkg;

  localparam int          MACW_DEF  = 48;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/route_rrpick.sv
`default_nettype none
// ============================================================================
// Module      : route_rrpick
// Description : Combinational round-robin picker. Returns the first asserted
//               request at or after ptr, searching cyclically past NREQ-1.
// Ports       : req   [NREQ] in  request vector
//               ptr   [PW]   in  highest-priority index
//               found        out any request asserted
//               idx   [PW]   out selected index (0 when found==0)
// Revision    : 1.0 - initial release
// ============================================================================
module route_rrpick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            found,
  output logic [PW-1:0]   idx
);

  logic [PW:0] sum;

  // Scan from the lowest priority to the highest so that the last hit,
  // which is the one closest to ptr, determines idx.
  always_comb begin
    found = |req;
    idx   = '0;
    sum   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PW + 1)'(i);
      if (sum >= (PW + 1)'(NREQ)) begin
        sum = sum - (PW + 1)'(NREQ);
      end
      if (req[sum[PW-1:0]]) begin
        idx = sum[PW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/route_lkup_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : route_lkup_arbiter
// Description : Shares the routing table's single destination-lookup port
//               among NREQ requesters. Round-robin arbitration, one lookup
//               outstanding, result returned only to the granted requester.
// Ports       : i_clk, i_reset_n      clock, synchronous active-low reset
//               REQ_VALID  [NREQ]     per-requester lookup request
//               REQ_DSTMAC [NREQ*MACW] per-requester destination MAC
//               REQ_ACK    [NREQ]     one-hot result strobe
//               REQ_PORT   [NETH]     lookup result (shared)
//               TBL_VALID/TBL_ACK/TBL_DSTMAC/TBL_PORT  routing-table port
//               o_busy                FSM not idle
//               o_timeout             lookup-timeout pulse
// Options     : ROUTE_LKUP_TIMEOUT_EN - abort a lookup after 2**LGTIMEOUT-1
//               WAIT cycles and return DEFAULT_PORT.
// Revision    : 1.0 - initial release
// ============================================================================
module route_lkup_arbiter
  import route_pkg::*;
#(
  parameter int              NREQ         = 4,
  parameter int              NETH         = 4,
  parameter int              MACW         = MACW_DEF,
  parameter logic [NETH-1:0] DEFAULT_PORT = {NETH{1'b1}},
  parameter int              LGTIMEOUT    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NREQ-1:0]      REQ_VALID,
  input  logic [NREQ*MACW-1:0] REQ_DSTMAC,
  output logic [NREQ-1:0]      REQ_ACK,
  output logic [NETH-1:0]      REQ_PORT,
  output logic                 TBL_VALID,
  input  logic                 TBL_ACK,
  output logic [MACW-1:0]      TBL_DSTMAC,
  input  logic [NETH-1:0]      TBL_PORT,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              tbl_valid_q, tbl_valid_d;
  logic [MACW-1:0]   tbl_dstmac_q, tbl_dstmac_d;
  logic [NREQ-1:0]   req_ack_q, req_ack_d;
  logic [NETH-1:0]   req_port_q, req_port_d;

  logic              pick_found;
  logic [PW-1:0]     pick_idx;

`ifdef ROUTE_LKUP_TIMEOUT_EN
  // Firing when the counter is one short of all-ones gives exactly
  // 2**LGTIMEOUT-1 WAIT cycles: the transition itself is the final increment.
  localparam logic [LGTIMEOUT-1:0] C_TO_LAST = {{(LGTIMEOUT-1){1'b1}}, 1'b0};
  logic [LGTIMEOUT-1:0] cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
`else
  logic [LGTIMEOUT+NETH-1:0] unused_cfg;
  assign unused_cfg = {{LGTIMEOUT{1'b0}}, DEFAULT_PORT};
`endif

  route_rrpick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (REQ_VALID),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    gidx_d       = gidx_q;
    ptr_d        = ptr_q;
    tbl_valid_d  = tbl_valid_q;
    tbl_dstmac_d = tbl_dstmac_q;
    req_ack_d    = '0;
    req_port_d   = req_port_q;
`ifdef ROUTE_LKUP_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gidx_d       = pick_idx;
          tbl_dstmac_d = REQ_DSTMAC[pick_idx*MACW +: MACW];
          tbl_valid_d  = 1'b1;
          state_d      = ST_WAIT;
`ifdef ROUTE_LKUP_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      ST_WAIT: begin
        // REQ_ACK is registered, so the "still requesting" test is made on
        // the edge that enters RESP; a requester that has withdrawn by then
        // gets no strobe and the result is dropped.
        if (TBL_ACK) begin
          tbl_valid_d       = 1'b0;
          req_port_d        = TBL_PORT;
          req_ack_d[gidx_q] = REQ_VALID[gidx_q];
          state_d           = ST_RESP;
        end
`ifdef ROUTE_LKUP_TIMEOUT_EN
        else if (cnt_q == C_TO_LAST) begin
          tbl_valid_d       = 1'b0;
          req_port_d        = DEFAULT_PORT;
          req_ack_d[gidx_q] = REQ_VALID[gidx_q];
          timeout_d         = 1'b1;
          state_d           = ST_RESP;
        end else begin
          cnt_d = cnt_q + LGTIMEOUT'(1);
        end
`endif
      end
      ST_RESP: begin
        ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      gidx_q       <= '0;
      ptr_q        <= '0;
      tbl_valid_q  <= 1'b0;
      tbl_dstmac_q <= '0;
      req_ack_q    <= '0;
      req_port_q   <= '0;
`ifdef ROUTE_LKUP_TIMEOUT_EN
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gidx_q       <= gidx_d;
      ptr_q        <= ptr_d;
      tbl_valid_q  <= tbl_valid_d;
      tbl_dstmac_q <= tbl_dstmac_d;
      req_ack_q    <= req_ack_d;
      req_port_q   <= req_port_d;
`ifdef ROUTE_LKUP_TIMEOUT_EN
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign REQ_ACK    = req_ack_q;
  assign REQ_PORT   = req_port_q;
  assign TBL_VALID  = tbl_valid_q;
  assign TBL_DSTMAC = tbl_dstmac_q;
  assign o_busy     = (state_q != ST_IDLE);
`ifdef ROUTE_LKUP_TIMEOUT_EN
  assign o_timeout  = timeout_q;
`else
  assign o_timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_route_lkup_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_route_lkup_arbiter
// Description : Scoreboard bench for route_lkup_arbiter (NREQ=4, NETH=4).
//               Stimulus pushes expected {REQ_ACK, REQ_PORT, cycle} entries;
//               a monitor pops one whenever REQ_ACK is non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_route_lkup_arbiter;

  localparam int NREQ = 4;
  localparam int NETH = 4;
  localparam int MACW = 48;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      REQ_VALID;
  logic [NREQ*MACW-1:0] REQ_DSTMAC;
  logic [NREQ-1:0]      REQ_ACK;
  logic [NETH-1:0]      REQ_PORT;
  logic                 TBL_VALID;
  logic                 TBL_ACK;
  logic [MACW-1:0]      TBL_DSTMAC;
  logic [NETH-1:0]      TBL_PORT;
  logic                 o_busy;
  logic                 o_timeout;

  route_lkup_arbiter #(
    .NREQ         (NREQ),
    .NETH         (NETH),
    .MACW         (MACW),
    .DEFAULT_PORT (4'b1111),
    .LGTIMEOUT    (4)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .REQ_VALID  (REQ_VALID),
    .REQ_DSTMAC (REQ_DSTMAC),
    .REQ_ACK    (REQ_ACK),
    .REQ_PORT   (REQ_PORT),
    .TBL_VALID  (TBL_VALID),
    .TBL_ACK    (TBL_ACK),
    .TBL_DSTMAC (TBL_DSTMAC),
    .TBL_PORT   (TBL_PORT),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NREQ-1:0] ack;
    logic [NETH-1:0] port;
    int              at;
  } exp_t;
  exp_t sb[$];

  bit mon_en = 1'b0;

  // routing-table model controls
  bit              tbl_stall = 1'b0;
  bit              spur_ack  = 1'b0;
  bit              fixed_en  = 1'b0;
  int              tbl_delay = 1;
  logic [NETH-1:0] fixed_port = '0;
  logic [NETH-1:0] spur_port  = '0;
  int              vcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NREQ-1:0] a, input logic [NETH-1:0] p, input int at);
    exp_t e;
    e.ack  = a;
    e.port = p;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic set_mac(input int n, input logic [MACW-1:0] v);
    REQ_DSTMAC[n*MACW +: MACW] = v;
  endtask

  // Bounded wait for the next REQ_ACK; the acked requester drops its request.
  task automatic wait_ack(input int limit);
    bit got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      if (REQ_ACK != '0) begin
        REQ_VALID = REQ_VALID & ~REQ_ACK;
        got = 1'b1;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_ack: no REQ_ACK within %0d cycles, got 0 expected 1", limit);
    end
  endtask

  // Table model: acks when TBL_VALID has been high for tbl_delay+1 cycles.
  // Runs 1 time unit after the stimulus so it sees this cycle's controls.
  initial begin
    TBL_ACK  = 1'b0;
    TBL_PORT = '0;
    forever begin
      @(posedge clk);
      #2;
      if (TBL_VALID) vcnt++;
      else vcnt = 0;
      if (spur_ack) begin
        TBL_ACK  = 1'b1;
        TBL_PORT = spur_port;
      end else if (TBL_VALID && !tbl_stall && vcnt >= tbl_delay + 1) begin
        TBL_ACK  = 1'b1;
        TBL_PORT = fixed_en ? fixed_port : TBL_DSTMAC[NETH-1:0];
      end else begin
        TBL_ACK  = 1'b0;
        TBL_PORT = '0;
      end
    end
  end

  // Monitor: every REQ_ACK pulse must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && REQ_ACK !== '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got %b expected none (cycle %0d)", REQ_ACK, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_mask", 64'(REQ_ACK), 64'(e.ack));
          chk("ack_port", 64'(REQ_PORT), 64'(e.port));
          chk("ack_cycle", 64'(cyc), 64'(e.at));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int   c;
  int   acks;
  int   n_hold;
  logic [NETH-1:0] exp_port;
  bit   exp_to;

  initial begin
    rst_n      = 1'b0;
    REQ_VALID  = '0;
    REQ_DSTMAC = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_req_ack",    64'(REQ_ACK),    64'h0);
    chk("rst_req_port",   64'(REQ_PORT),   64'h0);
    chk("rst_tbl_valid",  64'(TBL_VALID),  64'h0);
    chk("rst_tbl_dstmac", 64'(TBL_DSTMAC), 64'h0);
    chk("rst_busy",       64'(o_busy),     64'h0);
    chk("rst_timeout",    64'(o_timeout),  64'h0);
    mon_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 2, table acks one cycle after TBL_VALID.
    set_mac(2, 48'h02_00_00_00_00_05);
    fixed_en   = 1'b1;
    fixed_port = 4'b0010;
    tbl_delay  = 1;
    REQ_VALID  = 4'b0100;
    c = cyc;
    push(4'b0100, 4'b0010, c + 3);
    tick();
    @(negedge clk);
    chk("t1_tbl_valid",  64'(TBL_VALID),  64'h1);
    chk("t1_tbl_dstmac", 64'(TBL_DSTMAC), 64'h0200_0000_0005);
    chk("t1_busy",       64'(o_busy),     64'h1);
    wait_ack(10);
    tick();

    // Pointer now 3: with 0,1,3 pending, requester 3 wins.
    fixed_en = 1'b0;
    for (int n = 0; n < NREQ; n++) set_mac(n, {44'h0A0_0000_0000, 4'(1 << n)});
    REQ_VALID = 4'b1011;
    c = cyc;
    push(4'b1000, 4'b1000, c + 3);
    wait_ack(10);
    REQ_VALID = '0;
    tick();

    // Fairness from reset with an immediate table ack: 0,1,2,3,0 every 3 cycles.
    reset_dut();
    tbl_delay = 0;
    REQ_VALID = 4'b1111;
    c = cyc;
    push(4'b0001, 4'b0001, c + 2);
    push(4'b0010, 4'b0010, c + 5);
    push(4'b0100, 4'b0100, c + 8);
    push(4'b1000, 4'b1000, c + 11);
    push(4'b0001, 4'b0001, c + 14);
    acks = 0;
    for (int i = 0; i < 40 && acks < 5; i++) begin
      tick();
      if (REQ_ACK != '0) acks++;
    end
    REQ_VALID = '0;
    chk("fair_ack_count", 64'(acks), 64'd5);
    tick();

    // Abandon: requester 1 withdraws during WAIT, requester 2 served next.
    tbl_delay = 3;
    REQ_VALID = 4'b0110;
    c = cyc;
    push(4'b0100, 4'b0100, c + 11);
    tick();
    tick();
    REQ_VALID = 4'b0100;
    wait_ack(20);
    tick();

    // Stall: table withholds its ack; request stays presented unchanged.
    set_mac(0, 48'hDEAD_BEEF_0001);
    tbl_stall = 1'b1;
    tbl_delay = 0;
`ifdef ROUTE_LKUP_TIMEOUT_EN
    n_hold   = 15;
    exp_port = 4'b1111;
    exp_to   = 1'b1;
`else
    n_hold   = 40;
    exp_port = 4'b0001;
    exp_to   = 1'b0;
`endif
    REQ_VALID = 4'b0001;
    c = cyc;
    push(4'b0001, exp_port, c + n_hold + 1);
    for (int i = 1; i <= n_hold; i++) begin
      tick();
`ifndef ROUTE_LKUP_TIMEOUT_EN
      if (i == n_hold) tbl_stall = 1'b0;
`endif
      @(negedge clk);
      chk("stall_tbl_valid",  64'(TBL_VALID),  64'h1);
      chk("stall_tbl_dstmac", 64'(TBL_DSTMAC), 64'hDEAD_BEEF_0001);
      chk("stall_busy",       64'(o_busy),     64'h1);
    end
    tick();
    REQ_VALID = '0;
    @(negedge clk);
    chk("stall_timeout", 64'(o_timeout), 64'(exp_to));
    tbl_stall = 1'b0;
    tick();

    // Reset during WAIT, followed by a late table ack.
    tbl_stall = 1'b1;
    REQ_VALID = 4'b0010;
    tick();
    rst_n     = 1'b0;
    REQ_VALID = '0;
    tick();
    rst_n     = 1'b1;
    spur_ack  = 1'b1;
    spur_port = 4'b1010;
    @(negedge clk);
    chk("mrst_req_ack",    64'(REQ_ACK),    64'h0);
    chk("mrst_req_port",   64'(REQ_PORT),   64'h0);
    chk("mrst_tbl_valid",  64'(TBL_VALID),  64'h0);
    chk("mrst_tbl_dstmac", 64'(TBL_DSTMAC), 64'h0);
    chk("mrst_busy",       64'(o_busy),     64'h0);
    tick();
    spur_ack  = 1'b0;
    tbl_stall = 1'b0;
    @(negedge clk);
    chk("late_ack_port", 64'(REQ_PORT), 64'h0);
    chk("late_ack_busy", 64'(o_busy),   64'h0);

    // Pointer was restored to 0 by reset.
    tick();
    tbl_delay = 1;
    REQ_VALID = 4'b1111;
    c = cyc;
    push(4'b0001, 4'b0001, c + 3);
    wait_ack(10);
    REQ_VALID = '0;
    tick();

    // Spurious table ack in IDLE must not disturb REQ_PORT.
    tick();
    spur_ack  = 1'b1;
    spur_port = 4'b1000;
    tick();
    spur_ack  = 1'b0;
    @(negedge clk);
    chk("spur_req_port", 64'(REQ_PORT), 64'h1);
    chk("spur_busy",     64'(o_busy),   64'h0);
    tick();
    @(negedge clk);
    chk("spur_req_port2", 64'(REQ_PORT), 64'h1);

    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
